mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the CPU's instruction-fetch port (I) and load/store port (D).
- Arbitrates between the two ports and sequences one outstanding memory transaction at a time.
- The memory has fixed read latency; the block routes read data back to the granted port.
- Lets the CPU move from separate instruction and data memories to a single memory.

Parameters:
- A_WIDTH, 32, address width of all ports.
- MEM_LAT, 2, memory latency in cycles from m_req to valid m_rdata; minimum 1.
- D_MAX, 4, maximum consecutive D grants while i_req is held high; after that, I is granted next.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- i_req  in  1  fetch request; held high until i_gnt.
- i_addr  in  A_WIDTH  fetch address.
- i_gnt  out  1  fetch granted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  32  fetch data.
- d_req  in  1  load/store request; held high until d_gnt.
- d_we  in  1  1 = store.
- d_addr  in  A_WIDTH  data address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data port granted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  32  load data.
- m_req  out  1  memory access strobe, single cycle.
- m_we  out  1  memory write enable.
- m_addr  out  A_WIDTH  memory address.
- m_wdata  out  32  memory write data.
- m_be  out  4  memory byte enables.
- m_rdata  in  32  memory read data, valid MEM_LAT cycles after m_req.
- busy  out  1  transaction outstanding.

Behaviour:
- Reset (rst==0 at an edge):
  - state goes to S_IDLE; latency counter and streak counter are cleared.
  - All outputs are 0 on the following cycle.
  - An in-flight transaction is dropped; its late m_rdata is never forwarded.
- State S_IDLE:
  - If any request is high, exactly one grant is asserted combinationally in the same cycle.
  - m_req=1 in that cycle, carrying the winner's address, data and control.
  - The owner is latched, cnt is loaded with MEM_LAT-1, and the next state is S_WAIT.
- State S_WAIT:
  - busy=1; no grants.
  - cnt decrements each cycle.
  - In the cycle cnt==0, the owner's rvalid=1 and its rdata=m_rdata (combinational pass-through).
  - d_rvalid also pulses for stores (write acknowledge); d_rdata is then don't-care but driven from m_rdata.
- Back-to-back transactions:
  - In the response cycle the arbiter may grant a new request, behaving as S_IDLE in that cycle.
  - Sustained throughput is one transaction per MEM_LAT cycles.
  - With MEM_LAT==1, a transaction is granted every cycle and its response arrives in the next cycle.
- Priority:
  - D beats I, because D belongs to the older instruction.
  - Exception: if streak==D_MAX and i_req==1, I wins.
- Streak counter:
  - Increments on a D grant while i_req==1.
  - Saturates at D_MAX.
  - Clears on any I grant, or on a D grant with i_req==0.
- Non-granted signals:
  - Outputs not driven by a grant are 0: m_req, m_we, m_be, m_addr, m_wdata.
  - Non-owner rvalid is 0; rdata outputs are 0 when their rvalid is 0.
- Requester-side cases:
  - A request withdrawn before grant is ignored; no state change.
  - Request signals changing after grant do not affect the outstanding transaction.
  - Requester inputs are sampled only in the grant cycle.
- A write with d_be==0 is passed to memory unchanged.
- Addresses are passed unmodified; no alignment checks.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {S_IDLE, S_WAIT}.
  - owner_t enum {OWN_I, OWN_D}.
  - Constant BE_NONE = 4'b0000.
- One sub-module: mem_arb_sel.
  - Combinational priority/anti-starvation grant selection.
  - Inputs: i_req, d_req, streak_sat, can_grant.
  - Outputs: i_gnt, d_gnt.
- FSM, counters and data muxing stay in the top module.

Test Plan:
- Reset and basic fetch (MEM_LAT=2): rst=0 for 2 cycles, then all outputs are 0.
  - i_req=1, i_addr=0x10 at cycle T → i_gnt=1 and m_req=1 with m_addr=0x10 at T.
  - i_rvalid=1 with i_rdata=0xDEADBEEF at T+2.
- Simultaneous requests: i_req=d_req=1 in S_IDLE → d_gnt at T.
  - I is held and granted at T+2, the D response cycle.
  - i_rvalid follows at T+4.
- Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678, d_be=4'b0011 → m_we=1 with matching fields for one cycle.
  - d_rvalid=1 two cycles later; i_rvalid stays 0.
- Starvation guard (D_MAX=4): d_req and i_req held high continuously → D granted 4 times, then I once, then D resumes.
- Reset mid-operation: grant D, then rst=0 in the next cycle → no d_rvalid ever appears.
  - After rst=1, a fresh i_req is granted immediately.
- MEM_LAT=1 streaming: i_req held for 5 cycles with incrementing addresses → i_gnt high every cycle.
  - i_rvalid trails by 1 cycle, with data in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selection: D has priority over I unless the D streak
// has saturated while I is waiting, in which case I wins once.
module mem_arb_sel (
  input  logic i_req,
  input  logic d_req,
  input  logic streak_sat,
  input  logic can_grant,
  output logic i_gnt,
  output logic d_gnt
);

  // At most one grant, and only when the arbiter can accept a new transaction.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (can_grant) begin
      if (i_req && (streak_sat || !d_req)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch (I) and
// load/store (D) ports. One transaction is outstanding at a time; read data
// returns MEM_LAT cycles after the strobe and is routed to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned D_MAX   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [A_WIDTH-1:0] i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [31:0]        i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [A_WIDTH-1:0] d_addr,
  input  logic [31:0]        d_wdata,
  input  logic [3:0]         d_be,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic               m_req,
  output logic               m_we,
  output logic [A_WIDTH-1:0] m_addr,
  output logic [31:0]        m_wdata,
  output logic [3:0]         m_be,
  input  logic [31:0]        m_rdata,
  output logic               busy
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STR_W = $clog2(D_MAX + 1);

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STR_W-1:0]   streak_q, streak_d;

  logic resp;
  logic can_grant;
  logic streak_sat;

  // The response cycle doubles as an idle cycle so transactions can overlap.
  assign resp       = (state_q == S_WAIT) && (cnt_q == '0);
  assign can_grant  = (state_q == S_IDLE) || resp;
  assign streak_sat = (streak_q == STR_W'(D_MAX));
  assign busy       = (state_q == S_WAIT);

  mem_arb_sel u_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .streak_sat (streak_sat),
    .can_grant  (can_grant),
    .i_gnt      (i_gnt),
    .d_gnt      (d_gnt)
  );

  // State, owner, latency and streak registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_I;
      cnt_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
    end
  end

  // Next-state: a new grant overrides the return to idle in the response cycle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;

    if ((state_q == S_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (resp) begin
      state_d = S_IDLE;
    end
    if (i_gnt || d_gnt) begin
      state_d = S_WAIT;
      owner_d = d_gnt ? OWN_D : OWN_I;
      cnt_d   = CNT_W'(MEM_LAT - 1);
    end

    if (i_gnt) begin
      streak_d = '0;
    end else if (d_gnt) begin
      if (!i_req) begin
        streak_d = '0;
      end else if (!streak_sat) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // Memory-side mux: only the granted port drives the strobe and its fields.
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = BE_NONE;
    if (d_gnt) begin
      m_req   = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_be    = d_be;
    end else if (i_gnt) begin
      m_req  = 1'b1;
      m_addr = i_addr;
    end
  end

  // Response routing: read data passes straight through to the owner only.
  always_comb begin
    i_rvalid = resp && (owner_q == OWN_I);
    d_rvalid = resp && (owner_q == OWN_D);
    i_rdata  = i_rvalid ? m_rdata : 32'h0;
    d_rdata  = d_rvalid ? m_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance 0 uses MEM_LAT=2, instance 1 uses MEM_LAT=1.
module tb_mem_port_arbiter;

  typedef struct {
    int          inst;
    bit          port;   // 0 = I, 1 = D
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_t;

  typedef struct {
    int          inst;
    bit          port;
    int          cyc;
    bit          store;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        i_req    [2];
  logic [31:0] i_addr   [2];
  logic        i_gnt    [2];
  logic        i_rvalid [2];
  logic [31:0] i_rdata  [2];
  logic        d_req    [2];
  logic        d_we     [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic [3:0]  d_be     [2];
  logic        d_gnt    [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata  [2];
  logic        m_req    [2];
  logic        m_we     [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_be     [2];
  logic [31:0] m_rdata  [2];
  logic        busy     [2];

  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  gnt_t gq[$];
  rsp_t rq[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'hC0DE0000) + 32'h11);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : 1;
    logic [31:0] pipe [2];

    // Fixed-latency memory model.
    always @(posedge clk) begin
      pipe[0] <= m_req[g] ? mem_f(m_addr[g]) : 32'h0;
      pipe[1] <= pipe[0];
    end
    assign m_rdata[g] = pipe[LAT-1];

    mem_port_arbiter #(
      .A_WIDTH (32),
      .MEM_LAT (LAT),
      .D_MAX   (4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_gnt    (i_gnt[g]),
      .i_rvalid (i_rvalid[g]),
      .i_rdata  (i_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_be     (d_be[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .m_req    (m_req[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_be     (m_be[g]),
      .m_rdata  (m_rdata[g]),
      .busy     (busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input int inst, input bit port, input int c, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    gnt_t e;
    e.inst = inst; e.port = port; e.cyc = c; e.we = we;
    e.addr = addr; e.wdata = wdata; e.be = be;
    gq.push_back(e);
  endtask

  task automatic push_rsp(input int inst, input bit port, input int c, input bit store,
                          input logic [31:0] data);
    rsp_t e;
    e.inst = inst; e.port = port; e.cyc = c; e.store = store; e.data = data;
    rq.push_back(e);
  endtask

  task automatic check_idle(input int k);
    checks++;
    if (i_gnt[k] || d_gnt[k] || i_rvalid[k] || d_rvalid[k] || m_req[k] || m_we[k] ||
        busy[k] || (i_rdata[k] != 0) || (d_rdata[k] != 0) || (m_addr[k] != 0) ||
        (m_wdata[k] != 0) || (m_be[k] != 0)) begin
      errors++;
      $display("FAIL idle_outputs inst=%0d cyc=%0d got gnt=%b%b rv=%b%b mreq=%b busy=%b maddr=%h want all zero",
               k, cyc, i_gnt[k], d_gnt[k], i_rvalid[k], d_rvalid[k], m_req[k], busy[k],
               m_addr[k]);
    end
  endtask

  // Monitor: compares every grant and every response against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (i_gnt[k] || d_gnt[k]) begin
          checks++;
          if (gq.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected inst=%0d cyc=%0d got i_gnt=%b d_gnt=%b want none",
                     k, cyc, i_gnt[k], d_gnt[k]);
          end else begin
            gnt_t e;
            e = gq.pop_front();
            if (e.inst != k || e.cyc != cyc || (i_gnt[k] && d_gnt[k]) || d_gnt[k] != e.port ||
                !m_req[k] || m_we[k] != e.we || m_addr[k] != e.addr ||
                m_wdata[k] != e.wdata || m_be[k] != e.be) begin
              errors++;
              $display("FAIL gnt inst=%0d cyc=%0d got i/d=%b%b mreq=%b we=%b a=%h wd=%h be=%h want inst=%0d cyc=%0d port=%0d we=%b a=%h wd=%h be=%h",
                       k, cyc, i_gnt[k], d_gnt[k], m_req[k], m_we[k], m_addr[k], m_wdata[k],
                       m_be[k], e.inst, e.cyc, e.port, e.we, e.addr, e.wdata, e.be);
            end
          end
        end else begin
          checks++;
          if (m_req[k] || m_we[k] || m_addr[k] != 0 || m_wdata[k] != 0 || m_be[k] != 0) begin
            errors++;
            $display("FAIL mem_idle inst=%0d cyc=%0d got mreq=%b we=%b a=%h wd=%h be=%h want zeros",
                     k, cyc, m_req[k], m_we[k], m_addr[k], m_wdata[k], m_be[k]);
          end
        end

        if (i_rvalid[k] || d_rvalid[k]) begin
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected inst=%0d cyc=%0d got i_rvalid=%b d_rvalid=%b want none",
                     k, cyc, i_rvalid[k], d_rvalid[k]);
          end else begin
            rsp_t r;
            logic [31:0] got;
            r = rq.pop_front();
            got = d_rvalid[k] ? d_rdata[k] : i_rdata[k];
            if (r.inst != k || r.cyc != cyc || (i_rvalid[k] && d_rvalid[k]) ||
                d_rvalid[k] != r.port || (!r.store && got != r.data)) begin
              errors++;
              $display("FAIL rsp inst=%0d cyc=%0d got i/d=%b%b data=%h want inst=%0d cyc=%0d port=%0d data=%h",
                       k, cyc, i_rvalid[k], d_rvalid[k], got, r.inst, r.cyc, r.port, r.data);
            end
          end
        end

        checks++;
        if ((!i_rvalid[k] && i_rdata[k] != 0) || (!d_rvalid[k] && d_rdata[k] != 0)) begin
          errors++;
          $display("FAIL rdata_gate inst=%0d cyc=%0d got i_rdata=%h d_rdata=%h want 0",
                   k, cyc, i_rdata[k], d_rdata[k]);
        end
      end
    end
  end

  initial begin
    int t;
    cyc    = 0;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0;
    end

    // Reset for two edges, then everything idle.
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_idle(0);
    check_idle(1);

    // Basic fetch.
    tick(); t = cyc;
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    push_gnt(0, 0, t, 0, 32'h10, 32'h0, 4'h0);
    push_rsp(0, 0, t + 2, 0, 32'hDEADBEEF);
    tick(); i_req[0] = 1'b0;
    repeat (3) tick();

    // Simultaneous requests: D first, I granted in the D response cycle.
    t = cyc;
    i_req[0] = 1'b1; i_addr[0] = 32'h20;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
    push_gnt(0, 1, t,     0, 32'h40, 32'h0, 4'h0);
    push_gnt(0, 0, t + 2, 0, 32'h20, 32'h0, 4'h0);
    push_rsp(0, 1, t + 2, 0, mem_f(32'h40));
    push_rsp(0, 0, t + 4, 0, mem_f(32'h20));
    tick(); d_req[0] = 1'b0;
    tick();
    tick(); i_req[0] = 1'b0;
    repeat (3) tick();

    // Store with partial byte enables.
    t = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200;
    d_wdata[0] = 32'h12345678; d_be[0] = 4'b0011;
    push_gnt(0, 1, t, 1, 32'h200, 32'h12345678, 4'b0011);
    push_rsp(0, 1, t + 2, 1, 32'h0);
    tick();
    d_req[0] = 1'b0; d_we[0] = 1'b0; d_wdata[0] = '0; d_be[0] = '0;
    repeat (3) tick();

    // Starvation guard: four D grants, one I grant, then D resumes.
    t = cyc;
    i_req[0] = 1'b1; i_addr[0] = 32'h30;
    d_req[0] = 1'b1; d_addr[0] = 32'h50;
    for (int n = 0; n < 4; n++) begin
      push_gnt(0, 1, t + 2 * n, 0, 32'h50, 32'h0, 4'h0);
    end
    push_gnt(0, 0, t + 8,  0, 32'h30, 32'h0, 4'h0);
    push_gnt(0, 1, t + 10, 0, 32'h50, 32'h0, 4'h0);
    for (int n = 1; n <= 4; n++) begin
      push_rsp(0, 1, t + 2 * n, 0, mem_f(32'h50));
    end
    push_rsp(0, 0, t + 10, 0, mem_f(32'h30));
    push_rsp(0, 1, t + 12, 0, mem_f(32'h50));
    repeat (11) tick();
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (3) tick();

    // Reset while a load is in flight: its response must never appear.
    t = cyc;
    d_req[0] = 1'b1; d_addr[0] = 32'h60;
    push_gnt(0, 1, t, 0, 32'h60, 32'h0, 4'h0);
    tick(); d_req[0] = 1'b0; rst = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    check_idle(0);
    tick(); t = cyc;
    i_req[0] = 1'b1; i_addr[0] = 32'h70;
    push_gnt(0, 0, t, 0, 32'h70, 32'h0, 4'h0);
    push_rsp(0, 0, t + 2, 0, mem_f(32'h70));
    tick(); i_req[0] = 1'b0;
    repeat (3) tick();

    // MEM_LAT=1 streaming on instance 1.
    t = cyc;
    for (int n = 0; n < 5; n++) begin
      i_req[1]  = 1'b1;
      i_addr[1] = 32'h100 + 32'(4 * n);
      push_gnt(1, 0, t + n, 0, i_addr[1], 32'h0, 4'h0);
      push_rsp(1, 0, t + n + 1, 0, mem_f(i_addr[1]));
      tick();
    end
    i_req[1] = 1'b0;
    repeat (3) tick();

    // Anything left over was never observed.
    checks++;
    if (gq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL pending got gnt_left=%0d rsp_left=%0d want 0 0", gq.size(), rq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
